// File: rtl/perturbation_irq_gen.sv
// Perturbation interrupt generator: raises irq_o in STANDARD, RANDOM or PC_TRIG mode,
// counts acknowledged interrupts and flags protocol errors until reset.
//
// state    | meaning
// S_IDLE   | no request pending; mode_i selects how the next interrupt is launched
// S_WAIT   | RANDOM mode delay countdown before asserting
// S_ASSERT | irq_o high with latched ID, held until the core acknowledges
module perturbation_irq_gen #(
    parameter int unsigned IRQ_ID_W   = 5,
    parameter logic [31:0] SEED       = 32'hACE1_2468,
    parameter logic [31:0] PC_TRIG_ID = 32'h12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         mode_i,
    input  logic                std_irq_req_i,
    input  logic [IRQ_ID_W-1:0] std_irq_id_i,
    input  logic [7:0]          rand_mask_i,
    input  logic [31:0]         pc_i,
    input  logic                pc_valid_i,
    input  logic [31:0]         pc_trig_value_i,
    output logic                irq_o,
    output logic [IRQ_ID_W-1:0] irq_id_o,
    input  logic                irq_ack_i,
    input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
    output logic                busy_o,
    output logic [15:0]         irq_count_o,
    output logic                err_o
);

    localparam logic [31:0] MODE_STANDARD = 32'h1;
    localparam logic [31:0] MODE_RANDOM   = 32'h2;
    localparam logic [31:0] MODE_PC_TRIG  = 32'h3;
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ASSERT
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lfsr_q;
    logic [7:0]          cnt_q, cnt_d;
    logic [IRQ_ID_W-1:0] id_q, id_d;
    logic                armed_q, armed_d;
    logic [15:0]         count_q, count_d;
    logic                err_q, err_d;
    logic                irq_q, busy_q;
    logic                pc_match;

    assign pc_match = pc_valid_i && (pc_i == pc_trig_value_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        armed_d = armed_q;
        count_d = count_q;
        err_d   = err_q;

        // Any valid non-matching PC re-arms, so each loop pass fires at most once
        if (pc_valid_i && (pc_i != pc_trig_value_i)) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                case (mode_i)
                    MODE_STANDARD: begin
                        if (std_irq_req_i) begin
                            id_d    = std_irq_id_i;
                            state_d = S_ASSERT;
                        end
                    end
                    MODE_RANDOM: begin
                        cnt_d   = lfsr_q[7:0] & rand_mask_i;
                        id_d    = lfsr_q[8 +: IRQ_ID_W];
                        state_d = S_WAIT;
                    end
                    MODE_PC_TRIG: begin
                        if (armed_q && pc_match) begin
                            id_d    = PC_TRIG_ID[IRQ_ID_W-1:0];
                            armed_d = 1'b0;
                            state_d = S_ASSERT;
                        end
                    end
                    default: ;
                endcase
            end
            S_WAIT: begin
                if (mode_i != MODE_RANDOM) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_ASSERT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ASSERT: begin
                if (irq_ack_i) begin
                    state_d = S_IDLE;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    if (irq_ack_id_i != id_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (irq_ack_i && (state_q != S_ASSERT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            id_q    <= '0;
            armed_q <= 1'b1;
            count_q <= 16'd0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            armed_q <= armed_d;
            count_q <= count_d;
            err_q   <= err_d;
            irq_q   <= (state_d == S_ASSERT);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign irq_o       = irq_q;
    assign irq_id_o    = id_q;
    assign busy_o      = busy_q;
    assign irq_count_o = count_q;
    assign err_o       = err_q;

endmodule

// File: doc/perturbation_irq_gen.md
# perturbation_irq_gen

Testbench-side interrupt generator for the RI5CY/Zeroriscy perturbation environment. It drives the core's interrupt request/ID lines and consumes the core's acknowledge. It supports the three perturbation modes (STANDARD = 32'h1, RANDOM = 32'h2, PC_TRIG = 32'h3). It sits between the perturbation mode control and the core's irq interface, and also provides statistics and protocol-error reporting to the bench.

## Interface
- IRQ_ID_W, 5, width of interrupt ID
- SEED, 32'hACE1_2468, LFSR reset value; must be nonzero
- PC_TRIG_ID, 32'h12, ID issued in PC_TRIG mode; low IRQ_ID_W bits used
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mode_i  in  32  perturbation mode; any value other than 1/2/3 means disabled
- std_irq_req_i  in  1  STANDARD-mode request strobe from the bench
- std_irq_id_i  in  IRQ_ID_W  ID for the STANDARD request, sampled with the strobe
- rand_mask_i  in  8  AND-mask applied to the RANDOM delay
- pc_i  in  32  core ID-stage PC
- pc_valid_i  in  1  pc_i qualifier
- pc_trig_value_i  in  32  PC that fires PC_TRIG
- irq_o  out  1  interrupt request to the core
- irq_id_o  out  IRQ_ID_W  interrupt ID; stable while irq_o is high
- irq_ack_i  in  1  core acknowledge
- irq_ack_id_i  in  IRQ_ID_W  ID acknowledged by the core
- busy_o  out  1  FSM not in IDLE
- irq_count_o  out  16  acknowledged interrupts, saturating
- err_o  out  1  sticky protocol error

## Operation
- FSM states: IDLE, WAIT, ASSERT.
- **LFSR**
  - 32-bit Galois, taps 0x8020_0003.
  - Shifts every cycle after reset; reset value is SEED.
- **IDLE**
  - mode 1: on std_irq_req_i, latch std_irq_id_i and go to ASSERT.
  - mode 2: load cnt = lfsr[7:0] & rand_mask_i and latch id = lfsr[8+IRQ_ID_W-1:8]; go to WAIT.
  - mode 3: if armed and pc_valid_i and pc_i == pc_trig_value_i, latch id = PC_TRIG_ID and go to ASSERT. Clear armed.
  - Other modes: stay in IDLE.
- **PC_TRIG re-arm**
  - armed resets to 1.
  - Set again on any cycle with pc_valid_i and pc_i != pc_trig_value_i, so one loop pass yields one interrupt.
- **WAIT**
  - If cnt == 0, go to ASSERT; otherwise cnt decrements.
  - If mode_i != 2 in WAIT, return to IDLE without asserting.
- **ASSERT**
  - irq_o = 1 with the latched ID, held until irq_ack_i.
  - Mode changes are ignored while in ASSERT; the request is never withdrawn.
- **Ack in ASSERT**
  - Go to IDLE and increment irq_count_o, saturating at 16'hFFFF.
  - If irq_ack_id_i != irq_id_o, set err_o.
- **Spurious ack**: irq_ack_i while not in ASSERT sets err_o.
- **err_o**: cleared only by reset.
- **Request collisions**: std_irq_req_i outside IDLE is dropped and is not queued.

## Timing
- **Reset values**
  - irq_o = 0, irq_id_o = 0, busy_o = 0, irq_count_o = 0, err_o = 0.
  - state = IDLE, armed = 1, lfsr = SEED.
  - Reset asserted mid-operation drops irq_o asynchronously.
- All outputs are registered.
- **Latency**
  - STANDARD: strobe in cycle N → irq_o high in N+1.
  - PC_TRIG: match in cycle N → irq_o high in N+1.
  - RANDOM: IDLE in cycle N with delay d → WAIT from N+1 → irq_o high in N+2+d.
- **Ack**
  - Ack in cycle M → irq_o low and busy_o low in M+1; count updated in M+1.
  - A new STANDARD strobe is accepted no earlier than M+1, so back-to-back interrupts have a minimum 1-cycle low gap.
- Ack in the same cycle that irq_o rises is legal and is handled as a normal ack.
- irq_id_o changes only on the IDLE→ASSERT/WAIT transition.

## Test plan
- **STANDARD request**
  - Stimulus: mode 1, std_irq_req_i with id 5'h0B in cycle 10.
  - Response: irq_o = 1 with id 0x0B from cycle 11; ack in cycle 14 with id 0x0B → irq_o = 0 in cycle 15, irq_count_o = 1, err_o = 0.
- **RANDOM delays**
  - Stimulus: mode 2, rand_mask_i = 0, ack each interrupt immediately.
  - Response: irq_o rises 2 cycles after each IDLE; with mask 0xFF, the measured delay equals the LFSR byte predicted by a reference model.
- **PC_TRIG match and re-arm**
  - Stimulus: mode 3, trigger 0x1C08, pc_i sequence 0x1C08, 0x1C08, 0x1C0C, 0x1C08 (all valid).
  - Response: exactly two interrupts, both id 0x12.
- **Protocol errors**
  - Stimulus: ack id 0x03 while irq_id_o = 0x0B; separately, an ack with irq_o low.
  - Response: err_o = 1 next cycle and stays set until reset.
- **Mode change and reset mid-operation**
  - Stimulus: in WAIT, switch mode to 1.
  - Response: IDLE next cycle with no irq.
  - Stimulus: in ASSERT, assert rst_i.
  - Response: irq_o = 0 immediately, count = 0.
- **Counter saturation**
  - Stimulus: force 65535 acks, then ack one more.
  - Response: irq_count_o stays 16'hFFFF.
